// File: rtl/forth_stack_engine.sv
// Forth data/return stack engine: TOS/NOS cached in registers, deeper entries in a
// synchronous RAM, with depth tracking, sticky error flags and a multi-cycle refill/PICK path.
module forth_stack_engine #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_BITS = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [3:0]            op,
   input  logic [WIDTH-1:0]      op_data,
   output logic [WIDTH-1:0]      tos,
   output logic [WIDTH-1:0]      nos,
   output logic [DEPTH_BITS+1:0] depth,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  illegal,
   input  logic                  error_clear
);

   localparam int DW    = DEPTH_BITS + 2;
   localparam int AW    = DEPTH_BITS;
   localparam int WORDS = 1 << DEPTH_BITS;
   localparam logic [DW-1:0] CAP = DW'(WORDS + 2);

   localparam logic [3:0] OP_NOP       = 4'd0;
   localparam logic [3:0] OP_PUSH      = 4'd1;
   localparam logic [3:0] OP_DROP      = 4'd2;
   localparam logic [3:0] OP_DUP       = 4'd3;
   localparam logic [3:0] OP_SWAP      = 4'd4;
   localparam logic [3:0] OP_OVER      = 4'd5;
   localparam logic [3:0] OP_ROT       = 4'd6;
   localparam logic [3:0] OP_REPLACE   = 4'd7;
   localparam logic [3:0] OP_POP2_PUSH = 4'd8;
   localparam logic [3:0] OP_PICK      = 4'd9;
   localparam logic [3:0] OP_CLEAR     = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REFILL  = 2'd1,
      ST_PICK_RD = 2'd2
   } state_t;

   // Valid/ready: an op transfers on a posedge where op_valid && op_ready; while
   // op_ready is low the requester holds op/op_data stable and op_valid is ignored.

   state_t           state_q, state_d;
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [WIDTH-1:0] nos_q, nos_d;
   logic [DW-1:0]    depth_q, depth_d;
   logic             rot_q, rot_d;
   logic             ovf_q, unf_q, ill_q;
   logic             ovf_set, unf_set, ill_set;

   logic [WIDTH-1:0] mem [WORDS];
   logic [WIDTH-1:0] ram_rdata;
   logic             ram_we;
   logic [AW-1:0]    ram_waddr, ram_raddr;
   logic [WIDTH-1:0] ram_wdata;

   logic             accept, grows, fail;
   logic [DW:0]      need_k;
   logic [DW-1:0]    pick_n;
   logic [DW:0]      pick_k;
   logic [DW-1:0]    depth_m2, depth_m3, pick_addr;

   assign op_ready = (state_q == ST_IDLE);
   assign accept   = op_valid && op_ready;
   assign pick_n   = op_data[DW-1:0];
   assign pick_k   = {1'b0, pick_n} + (DW+1)'(1);
   // RAM holds depth-2 entries; its top word sits at depth-3, the next spill slot at depth-2.
   assign depth_m2  = depth_q - DW'(2);
   assign depth_m3  = depth_q - DW'(3);
   assign pick_addr = depth_q - DW'(1) - pick_n;

   always_comb begin
      need_k  = '0;
      grows   = 1'b0;
      ill_set = 1'b0;
      case (op)
         OP_NOP:       need_k = '0;
         OP_PUSH:      grows  = 1'b1;
         OP_DROP:      need_k = (DW+1)'(1);
         OP_DUP:       begin need_k = (DW+1)'(1); grows = 1'b1; end
         OP_SWAP:      need_k = (DW+1)'(2);
         OP_OVER:      begin need_k = (DW+1)'(2); grows = 1'b1; end
         OP_ROT:       need_k = (DW+1)'(3);
         OP_REPLACE:   need_k = (DW+1)'(1);
         OP_POP2_PUSH: need_k = (DW+1)'(2);
         OP_PICK:      begin need_k = pick_k; grows = 1'b1; end
         OP_CLEAR:     need_k = '0;
         default:      ill_set = accept;
      endcase
      unf_set = accept && ({1'b0, depth_q} < need_k);
      ovf_set = accept && grows && (depth_q == CAP);
      fail    = unf_set || ovf_set || ill_set;
   end

   always_comb begin
      state_d   = state_q;
      tos_d     = tos_q;
      nos_d     = nos_q;
      depth_d   = depth_q;
      rot_d     = rot_q;
      ram_we    = 1'b0;
      ram_waddr = depth_m2[AW-1:0];
      ram_wdata = nos_q;
      ram_raddr = depth_m3[AW-1:0];
      case (state_q)
         ST_IDLE: begin
            if (accept && !fail) begin
               // Growing ops (except the RAM-reading PICK) spill NOS into the next free slot.
               if (grows && (depth_q >= DW'(2)) && !(op == OP_PICK && pick_n >= DW'(2)))
                  ram_we = 1'b1;
               case (op)
                  OP_PUSH: begin
                     nos_d   = tos_q;
                     tos_d   = op_data;
                     depth_d = depth_q + DW'(1);
                  end
                  OP_DUP: begin
                     nos_d   = tos_q;
                     depth_d = depth_q + DW'(1);
                  end
                  OP_OVER: begin
                     nos_d   = tos_q;
                     tos_d   = nos_q;
                     depth_d = depth_q + DW'(1);
                  end
                  OP_PICK: begin
                     if (pick_n == DW'(0)) begin
                        nos_d   = tos_q;
                        depth_d = depth_q + DW'(1);
                     end else if (pick_n == DW'(1)) begin
                        nos_d   = tos_q;
                        tos_d   = nos_q;
                        depth_d = depth_q + DW'(1);
                     end else begin
                        ram_raddr = pick_addr[AW-1:0];
                        state_d   = ST_PICK_RD;
                     end
                  end
                  OP_SWAP: begin
                     tos_d = nos_q;
                     nos_d = tos_q;
                  end
                  OP_DROP, OP_POP2_PUSH: begin
                     tos_d   = (op == OP_DROP) ? nos_q : op_data;
                     depth_d = depth_q - DW'(1);
                     if (depth_q >= DW'(3)) begin
                        rot_d   = 1'b0;
                        state_d = ST_REFILL;
                     end
                  end
                  OP_ROT: begin
                     rot_d   = 1'b1;
                     state_d = ST_REFILL;
                  end
                  OP_REPLACE: tos_d   = op_data;
                  OP_CLEAR:   depth_d = '0;
                  default: ;
               endcase
            end
         end
         ST_REFILL: begin
            state_d = ST_IDLE;
            if (rot_q) begin
               // ( a b c -- b c a ): a comes up from RAM, b takes its slot.
               ram_we    = 1'b1;
               ram_waddr = depth_m3[AW-1:0];
               tos_d     = ram_rdata;
               nos_d     = tos_q;
            end else begin
               nos_d = ram_rdata;
            end
         end
         ST_PICK_RD: begin
            state_d = ST_IDLE;
            ram_we  = 1'b1;
            tos_d   = ram_rdata;
            nos_d   = tos_q;
            depth_d = depth_q + DW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         tos_q   <= '0;
         nos_q   <= '0;
         depth_q <= '0;
         rot_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tos_q   <= tos_d;
         nos_q   <= nos_d;
         depth_q <= depth_d;
         rot_q   <= rot_d;
         // A fresh error beats a simultaneous clear.
         ovf_q   <= (ovf_q && !error_clear) || ovf_set;
         unf_q   <= (unf_q && !error_clear) || unf_set;
         ill_q   <= (ill_q && !error_clear) || ill_set;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we)
         mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   assign tos       = (depth_q == '0) ? '0 : tos_q;
   assign nos       = (depth_q < DW'(2)) ? '0 : nos_q;
   assign depth     = depth_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_forth_stack_engine.sv
// Directed bench for forth_stack_engine with DEPTH_BITS=2 (CAP=6), WIDTH=16.
module tb_forth_stack_engine;

   localparam int W  = 16;
   localparam int DB = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          op_valid = 1'b0;
   logic          op_ready;
   logic [3:0]    op = 4'd0;
   logic [W-1:0]  op_data = '0;
   logic [W-1:0]  tos, nos;
   logic [DB+1:0] depth;
   logic          overflow, underflow, illegal;
   logic          error_clear = 1'b0;

   int checks = 0;
   int errors = 0;

   forth_stack_engine #(.WIDTH(W), .DEPTH_BITS(DB)) dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op(op), .op_data(op_data), .tos(tos), .nos(nos), .depth(depth),
      .overflow(overflow), .underflow(underflow), .illegal(illegal),
      .error_clear(error_clear)
   );

   always #5 clk = ~clk;

   task automatic apply_reset;
      reset = 1'b1; op_valid = 1'b0; error_clear = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Waits (bounded) for op_ready, then presents one op for exactly one accepting edge.
   task automatic issue(input logic [3:0] o, input logic [W-1:0] d);
      int guard = 0;
      while (!op_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      checks++;
      if (!op_ready) begin errors++; $display("FAIL issue_ready_timeout op=%0d ready=%b required 1", o, op_ready); end
      op_valid = 1'b1; op = o; op_data = d;
      @(posedge clk); #1;
      op_valid = 1'b0;
   endtask

   task automatic settle;
      int guard = 0;
      while (!op_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      checks++;
      if (!op_ready) begin errors++; $display("FAIL settle_timeout ready=%b required 1", op_ready); end
   endtask

   task automatic test_reset;
      apply_reset;
      checks++; if (depth !== 4'd0) begin errors++; $display("FAIL reset_depth got %0d want 0", depth); end
      checks++; if (tos !== 16'h0) begin errors++; $display("FAIL reset_tos got %h want 0", tos); end
      checks++; if (nos !== 16'h0) begin errors++; $display("FAIL reset_nos got %h want 0", nos); end
      checks++; if ({overflow, underflow, illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {overflow, underflow, illegal}); end
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", op_ready); end
   endtask

   task automatic test_rot_drop;
      apply_reset;
      issue(4'd1, 16'h1111); issue(4'd1, 16'h2222); issue(4'd1, 16'h3333);
      checks++; if (tos !== 16'h3333) begin errors++; $display("FAIL push3_tos got %h want 3333", tos); end
      checks++; if (nos !== 16'h2222) begin errors++; $display("FAIL push3_nos got %h want 2222", nos); end
      checks++; if (depth !== 4'd3) begin errors++; $display("FAIL push3_depth got %0d want 3", depth); end
      issue(4'd6, 16'h0);
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL rot_busy got %b want 0", op_ready); end
      @(posedge clk); #1;
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL rot_ready_after1 got %b want 1", op_ready); end
      checks++; if (tos !== 16'h1111) begin errors++; $display("FAIL rot_tos got %h want 1111", tos); end
      checks++; if (nos !== 16'h3333) begin errors++; $display("FAIL rot_nos got %h want 3333", nos); end
      checks++; if (depth !== 4'd3) begin errors++; $display("FAIL rot_depth got %0d want 3", depth); end
      issue(4'd2, 16'h0);
      settle;
      checks++; if (nos !== 16'h2222) begin errors++; $display("FAIL drop1_nos got %h want 2222", nos); end
      issue(4'd2, 16'h0);
      checks++; if (tos !== 16'h2222) begin errors++; $display("FAIL drop2_tos got %h want 2222", tos); end
      checks++; if (depth !== 4'd1) begin errors++; $display("FAIL drop2_depth got %0d want 1", depth); end
   endtask

   task automatic test_overflow;
      apply_reset;
      for (int i = 1; i <= 6; i++) issue(4'd1, W'(i));
      checks++; if (depth !== 4'd6) begin errors++; $display("FAIL full_depth got %0d want 6", depth); end
      issue(4'd1, 16'd7);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
      checks++; if (depth !== 4'd6) begin errors++; $display("FAIL ovf_depth got %0d want 6", depth); end
      checks++; if (tos !== 16'd6) begin errors++; $display("FAIL ovf_tos got %0d want 6", tos); end
      checks++; if (nos !== 16'd5) begin errors++; $display("FAIL ovf_nos got %0d want 5", nos); end
      error_clear = 1'b1; @(posedge clk); #1 error_clear = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
      error_clear = 1'b1;
      issue(4'd1, 16'd8);
      error_clear = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_beats_clear got %b want 1", overflow); end
      // Deep RAM contents survive: drop down to verify spilled entries.
      issue(4'd2, 16'h0); settle;
      checks++; if (nos !== 16'd4) begin errors++; $display("FAIL full_drop_nos got %0d want 4", nos); end
   endtask

   task automatic test_underflow_illegal;
      apply_reset;
      issue(4'd2, 16'h0);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_drop got %b want 1", underflow); end
      checks++; if (depth !== 4'd0) begin errors++; $display("FAIL unf_depth got %0d want 0", depth); end
      checks++; if (tos !== 16'h0) begin errors++; $display("FAIL unf_tos got %h want 0", tos); end
      issue(4'd1, 16'd5);
      issue(4'd4, 16'h0);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b want 1", underflow); end
      checks++; if (tos !== 16'd5) begin errors++; $display("FAIL unf_swap_tos got %h want 5", tos); end
      checks++; if (nos !== 16'h0) begin errors++; $display("FAIL unf_swap_nos got %h want 0", nos); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_pre got %b want 0", illegal); end
      issue(4'd12, 16'h0);
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_set got %b want 1", illegal); end
      checks++; if ({overflow, depth} !== {1'b0, 4'd1}) begin errors++; $display("FAIL ill_state got ovf=%b depth=%0d want ovf=0 depth=1", overflow, depth); end
   endtask

   task automatic test_pick;
      apply_reset;
      issue(4'd1, 16'd10); issue(4'd1, 16'd20); issue(4'd1, 16'd30); issue(4'd1, 16'd40);
      issue(4'd9, 16'd3);
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL pick_busy got %b want 0", op_ready); end
      @(posedge clk); #1;
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL pick_ready got %b want 1", op_ready); end
      checks++; if (tos !== 16'd10) begin errors++; $display("FAIL pick3_tos got %0d want 10", tos); end
      checks++; if (nos !== 16'd40) begin errors++; $display("FAIL pick3_nos got %0d want 40", nos); end
      checks++; if (depth !== 4'd5) begin errors++; $display("FAIL pick3_depth got %0d want 5", depth); end
      issue(4'd9, 16'd5);
      checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL pick5_unf got %b want 1", underflow); end
      checks++; if (depth !== 4'd5) begin errors++; $display("FAIL pick5_depth got %0d want 5", depth); end
      issue(4'd2, 16'h0); settle;
      checks++; if ({tos, nos} !== {16'd40, 16'd30}) begin errors++; $display("FAIL pick_drop got %0d/%0d want 40/30", tos, nos); end
      issue(4'd2, 16'h0); settle;
      issue(4'd9, 16'd1);
      checks++; if ({tos, nos, depth} !== {16'd20, 16'd30, 4'd4}) begin errors++; $display("FAIL pick1 got %0d/%0d/%0d want 20/30/4", tos, nos, depth); end
   endtask

   task automatic test_pop2_replace;
      apply_reset;
      issue(4'd1, 16'd10); issue(4'd1, 16'd20); issue(4'd1, 16'd30);
      issue(4'd8, 16'h0050);
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL pop2_busy got %b want 0", op_ready); end
      settle;
      checks++; if ({tos, nos, depth} !== {16'h0050, 16'd10, 4'd2}) begin errors++; $display("FAIL pop2 got %h/%h/%0d want 0050/000a/2", tos, nos, depth); end
      issue(4'd7, 16'h00AA);
      checks++; if ({tos, nos, depth} !== {16'h00AA, 16'd10, 4'd2}) begin errors++; $display("FAIL replace got %h/%h/%0d want 00aa/000a/2", tos, nos, depth); end
      issue(4'd3, 16'h0);
      checks++; if ({tos, nos, depth} !== {16'h00AA, 16'h00AA, 4'd3}) begin errors++; $display("FAIL dup got %h/%h/%0d want 00aa/00aa/3", tos, nos, depth); end
      issue(4'd5, 16'h0);
      checks++; if ({tos, nos, depth} !== {16'h00AA, 16'h00AA, 4'd4}) begin errors++; $display("FAIL over got %h/%h/%0d want 00aa/00aa/4", tos, nos, depth); end
      issue(4'd10, 16'h0);
      checks++; if ({tos, nos, depth} !== {16'h0, 16'h0, 4'd0}) begin errors++; $display("FAIL clear got %h/%h/%0d want 0/0/0", tos, nos, depth); end
   endtask

   task automatic test_reset_in_refill;
      apply_reset;
      issue(4'd1, 16'd1); issue(4'd1, 16'd2); issue(4'd1, 16'd3);
      issue(4'd13, 16'h0);
      issue(4'd6, 16'h0);
      checks++; if (op_ready !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", op_ready); end
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      checks++; if ({depth, tos} !== {4'd0, 16'h0}) begin errors++; $display("FAIL abort_state got %0d/%h want 0/0", depth, tos); end
      checks++; if (op_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", op_ready); end
      checks++; if ({overflow, underflow, illegal} !== 3'b000) begin errors++; $display("FAIL abort_flags got %b want 000", {overflow, underflow, illegal}); end
   endtask

   initial begin
      test_reset;
      test_rot_drop;
      test_overflow;
      test_underflow_illegal;
      test_pick;
      test_pop2_replace;
      test_reset_in_refill;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
